// File: rtl/reduce_nway_seq.sv
// reduce_nway_seq: sequential N-way OR/AND/XOR/NOR reduction with
// lowest-set-bit index, LANE bits per cycle, valid/ready on both sides.
module reduce_nway_seq #(
   parameter int WIDTH = 64,
   parameter int LANE  = 8,
   localparam int CHUNKS = WIDTH / LANE,
   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out,
   output logic             found,
   output logic [IDXW-1:0]  first_idx
);

   localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int LW = (LANE > 1) ? $clog2(LANE) : 1;

   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [1:0]       opr;
   logic             acc;
   logic [CW-1:0]    cnt;
   logic [IDXW-1:0]  base;

   logic [LANE-1:0]  chunk;
   logic             acc_n;
   logic [LW-1:0]    lo;
   logic             last;

   assign in_ready = (state == IDLE);
   assign chunk    = sh[LANE-1:0];
   assign last     = (cnt == CW'(CHUNKS - 1));

   // fold the current chunk into the running reduction
   always_comb begin
      acc_n = acc;
      unique case (opr)
         OP_AND:  acc_n = acc & (&chunk);
         OP_XOR:  acc_n = acc ^ (^chunk);
         default: acc_n = acc | (|chunk);
      endcase
   end

   // position of the lowest set bit inside the current chunk
   always_comb begin
      lo = '0;
      for (int i = LANE - 1; i >= 0; i--) begin
         if (chunk[i]) lo = LW'(i);
      end
   end

   // control FSM with registered datapath and outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sh        <= '0;
         opr       <= '0;
         acc       <= 1'b0;
         cnt       <= '0;
         base      <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         found     <= 1'b0;
         first_idx <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sh        <= in;
                  opr       <= op;
                  acc       <= (op == OP_AND);
                  cnt       <= '0;
                  base      <= '0;
                  found     <= 1'b0;
                  first_idx <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               acc  <= acc_n;
               sh   <= sh >> LANE;
               cnt  <= cnt + CW'(1);
               base <= base + IDXW'(LANE);
               if (!found && (|chunk)) begin
                  found     <= 1'b1;
                  first_idx <= base + IDXW'(lo);
               end
               if (last) begin
                  out       <= (opr == OP_NOR) ? ~acc_n : acc_n;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
